// File: rtl/fpnew_wb_buffer_pkg.sv
// Shared types for the FPU writeback buffer.
// status_t mirrors the FPU exception-flag layout {NV,DZ,OF,UF,NX}, with NV in the MSB.
package fpnew_wb_buffer_pkg;

    // Number of IEEE exception flags carried with every result
    localparam int unsigned STATUS_W = 5;

    // Exception flags in fflags bit order: NV is bit 4, NX is bit 0
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

endpackage

// File: rtl/fpnew_wb_buffer.sv
// FPU output buffer sitting between the FPU and the FP register-file writeback port.
// Results are queued in order, so the FPU only sees back-pressure from the registered fill level.
// Exception flags are accrued into the sticky fflags register only when an entry is
// actually consumed by writeback. Entries thrown away by a flush never touch fflags.
module fpnew_wb_buffer
    import fpnew_wb_buffer_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             fpu_result_i,
    input  logic [STATUS_W-1:0]          fpu_status_i,
    input  logic [TAG_WIDTH-1:0]         fpu_tag_i,
    input  logic                         fpu_valid_i,
    output logic                         fpu_ready_o,
    output logic [WIDTH-1:0]             wb_result_o,
    output logic [STATUS_W-1:0]          wb_status_o,
    output logic [TAG_WIDTH-1:0]         wb_tag_o,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    input  logic                         fflags_we_i,
    input  logic                         fflags_clr_i,
    input  logic [STATUS_W-1:0]          fflags_wdata_i,
    output logic [STATUS_W-1:0]          fflags_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    output logic                         busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // One buffered FPU result together with its flags and destination tag
    typedef struct packed {
        logic [WIDTH-1:0]     result;
        status_t              status;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [CNT_W-1:0]     r_count;
    logic [STATUS_W-1:0]  r_fflags;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_notFull;
    logic                 w_notEmpty;
    entry_t               w_head;
    entry_t               w_newEntry;
    logic [STATUS_W-1:0]  w_popStatus;
    logic [PTR_W-1:0]     w_wrPtrInc;
    logic [PTR_W-1:0]     w_rdPtrInc;
    logic [CNT_W-1:0]     w_countNext;
    logic [STATUS_W-1:0]  w_fflagsNext;

    // Handshake qualifiers; ready depends only on the registered count
    always_comb begin
        w_notFull  = (r_count != FULL_CNT);
        w_notEmpty = (r_count != '0);
        w_push     = fpu_valid_i && w_notFull && !flush_i;
        w_pop      = w_notEmpty && wb_ready_i;
    end

    // Head entry and the status it contributes to fflags when it commits
    always_comb begin
        w_head      = r_mem[r_rdPtr];
        w_popStatus = w_pop ? STATUS_W'(w_head.status) : '0;
    end

    // Pack the incoming FPU result into a buffer entry
    always_comb begin
        w_newEntry        = '0;
        w_newEntry.result = fpu_result_i;
        w_newEntry.status = status_t'(fpu_status_i);
        w_newEntry.tag    = fpu_tag_i;
    end

    // Pointer increments with wrap at DEPTH-1, so non power-of-two depths work
    always_comb begin
        w_wrPtrInc = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
        w_rdPtrInc = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
    end

    // Occupancy moves by push minus pop; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CNT_W'(1);
        end
    end

    // Sticky flag update: a CSR write beats a clear, and a committing entry is always ORed in
    always_comb begin
        w_fflagsNext = r_fflags | w_popStatus;
        if (fflags_we_i) begin
            w_fflagsNext = fflags_wdata_i | w_popStatus;
        end else if (fflags_clr_i) begin
            w_fflagsNext = w_popStatus;
        end
    end

    // Pointer and occupancy registers; a flush empties the buffer and drops any same-cycle push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= w_wrPtrInc;
            end
            if (w_pop) begin
                r_rdPtr <= w_rdPtrInc;
            end
            r_count <= w_countNext;
        end
    end

    // Sticky fflags register; a pop during a flush still commits because writeback consumed it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fflags <= '0;
        end else begin
            r_fflags <= w_fflagsNext;
        end
    end

    // Entry storage has no reset; only slots below the count are ever observed
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_newEntry;
        end
    end

    // Output drive straight from registers, so a push is never visible in the same cycle
    always_comb begin
        fpu_ready_o = w_notFull;
        wb_valid_o  = w_notEmpty;
        wb_result_o = w_head.result;
        wb_status_o = STATUS_W'(w_head.status);
        wb_tag_o    = w_head.tag;
        fflags_o    = r_fflags;
        usage_o     = r_count;
        busy_o      = w_notEmpty;
    end

`ifndef SYNTHESIS
    // Protocol sanity checks on the internal handshakes
    property p_noPushWhenFull;
        @(posedge clk_i) disable iff (!rst_ni) !(w_push && (r_count == FULL_CNT));
    endproperty

    property p_noPopWhenEmpty;
        @(posedge clk_i) disable iff (!rst_ni) !(w_pop && (r_count == '0));
    endproperty

    property p_headStable;
        @(posedge clk_i) disable iff (!rst_ni)
            (wb_valid_o && !wb_ready_i && !flush_i) |=>
                ($stable(wb_result_o) && $stable(wb_status_o) && $stable(wb_tag_o) && wb_valid_o);
    endproperty

    a_noPushWhenFull  : assert property (p_noPushWhenFull);
    a_noPopWhenEmpty  : assert property (p_noPopWhenEmpty);
    a_headStable      : assert property (p_headStable);
`endif

endmodule

// File: tb/tb_fpnew_wb_buffer.sv
// Self-checking bench for fpnew_wb_buffer.
// Inputs change on the falling edge and outputs are compared on the falling edge against
// a queue-based reference model that is advanced at every rising edge.
module tb_fpnew_wb_buffer;

    localparam int unsigned WIDTH     = 64;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TAG_WIDTH = 5;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    typedef struct {
        logic [WIDTH-1:0]     result;
        logic [4:0]           status;
        logic [TAG_WIDTH-1:0] tag;
    } model_entry_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 flush_i;
    logic [WIDTH-1:0]     fpu_result_i;
    logic [4:0]           fpu_status_i;
    logic [TAG_WIDTH-1:0] fpu_tag_i;
    logic                 fpu_valid_i;
    logic                 fpu_ready_o;
    logic [WIDTH-1:0]     wb_result_o;
    logic [4:0]           wb_status_o;
    logic [TAG_WIDTH-1:0] wb_tag_o;
    logic                 wb_valid_o;
    logic                 wb_ready_i;
    logic                 fflags_we_i;
    logic                 fflags_clr_i;
    logic [4:0]           fflags_wdata_i;
    logic [4:0]           fflags_o;
    logic [CNT_W-1:0]     usage_o;
    logic                 busy_o;

    model_entry_t mQueue[$];
    logic [4:0]   mFflags;
    int           nChecks = 0;
    int           nErrors = 0;

    fpnew_wb_buffer #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .TAG_WIDTH (TAG_WIDTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .fpu_result_i   (fpu_result_i),
        .fpu_status_i   (fpu_status_i),
        .fpu_tag_i      (fpu_tag_i),
        .fpu_valid_i    (fpu_valid_i),
        .fpu_ready_o    (fpu_ready_o),
        .wb_result_o    (wb_result_o),
        .wb_status_o    (wb_status_o),
        .wb_tag_o       (wb_tag_o),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .fflags_we_i    (fflags_we_i),
        .fflags_clr_i   (fflags_clr_i),
        .fflags_wdata_i (fflags_wdata_i),
        .fflags_o       (fflags_o),
        .usage_o        (usage_o),
        .busy_o         (busy_o)
    );

    // Free-running clock, 10 time units per period
    always #5 clk_i = ~clk_i;

    // Put every data-path input into a quiet state
    task automatic idleInputs();
        flush_i        = 1'b0;
        fpu_result_i   = '0;
        fpu_status_i   = '0;
        fpu_tag_i      = '0;
        fpu_valid_i    = 1'b0;
        wb_ready_i     = 1'b0;
        fflags_we_i    = 1'b0;
        fflags_clr_i   = 1'b0;
        fflags_wdata_i = '0;
    endtask

    // Present one FPU result on the input side
    task automatic driveFpu(input logic [WIDTH-1:0] res, input logic [4:0] st, input logic [TAG_WIDTH-1:0] tg);
        fpu_valid_i  = 1'b1;
        fpu_result_i = res;
        fpu_status_i = st;
        fpu_tag_i    = tg;
    endtask

    // Clock one cycle and apply the buffer rules to the model using the inputs seen at the edge
    task automatic advance();
        bit           doPush;
        bit           doPop;
        logic [4:0]   popSt;
        model_entry_t e;
        doPush = fpu_valid_i && (mQueue.size() != DEPTH) && !flush_i;
        doPop  = (mQueue.size() != 0) && wb_ready_i;
        popSt  = doPop ? mQueue[0].status : 5'b0;
        e.result = fpu_result_i;
        e.status = fpu_status_i;
        e.tag    = fpu_tag_i;
        if (fflags_we_i)       mFflags = fflags_wdata_i | popSt;
        else if (fflags_clr_i) mFflags = popSt;
        else                   mFflags = mFflags | popSt;
        @(posedge clk_i);
        if (doPop) void'(mQueue.pop_front());
        if (flush_i) mQueue.delete();
        else if (doPush) mQueue.push_back(e);
        @(negedge clk_i);
    endtask

    // Outputs during and after reset
    task automatic test_reset();
        idleInputs();
        rst_ni = 1'b0;
        mQueue.delete();
        mFflags = '0;
        repeat (3) @(negedge clk_i);
        nChecks++;
        if ({wb_valid_o, busy_o, usage_o, fflags_o, fpu_ready_o} !== {1'b0, 1'b0, CNT_W'(0), 5'b0, 1'b1}) begin
            nErrors++;
            $display("[TB] FAIL reset_in valid=%b busy=%b usage=%0d fflags=%b ready=%b required 0 0 0 00000 1",
                     wb_valid_o, busy_o, usage_o, fflags_o, fpu_ready_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        nChecks++;
        if ({wb_valid_o, busy_o, usage_o, fflags_o, fpu_ready_o} !== {1'b0, 1'b0, CNT_W'(0), 5'b0, 1'b1}) begin
            nErrors++;
            $display("[TB] FAIL reset_out valid=%b busy=%b usage=%0d fflags=%b ready=%b required 0 0 0 00000 1",
                     wb_valid_o, busy_o, usage_o, fflags_o, fpu_ready_o);
        end
    endtask

    // Single push then pop, including no fall-through and the fflags commit
    task automatic test_single();
        idleInputs();
        driveFpu(64'h3FF0000000000000, 5'b00001, 5'd3);
        nChecks++;
        if (wb_valid_o !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL single_nofallthrough wb_valid=%b required 0", wb_valid_o);
        end
        advance();
        idleInputs();
        nChecks++;
        if ({wb_valid_o, wb_result_o, wb_status_o, wb_tag_o} !== {1'b1, 64'h3FF0000000000000, 5'b00001, 5'd3}) begin
            nErrors++;
            $display("[TB] FAIL single_head valid=%b res=%h st=%b tag=%0d required 1 3ff0000000000000 00001 3",
                     wb_valid_o, wb_result_o, wb_status_o, wb_tag_o);
        end
        nChecks++;
        if (fflags_o !== 5'b00000) begin
            nErrors++;
            $display("[TB] FAIL single_flags_early fflags=%b required 00000", fflags_o);
        end
        wb_ready_i = 1'b1;
        advance();
        idleInputs();
        nChecks++;
        if ({fflags_o, usage_o, wb_valid_o} !== {5'b00001, CNT_W'(0), 1'b0}) begin
            nErrors++;
            $display("[TB] FAIL single_pop fflags=%b usage=%0d valid=%b required 00001 0 0",
                     fflags_o, usage_o, wb_valid_o);
        end
    endtask

    // Fill while stalled, refuse a fifth push, then drain in order with a stable head
    task automatic test_full_stall();
        idleInputs();
        for (int i = 1; i <= 4; i++) begin
            driveFpu({$urandom, $urandom}, 5'b0, TAG_WIDTH'(i));
            advance();
        end
        nChecks++;
        if ({fpu_ready_o, usage_o} !== {1'b0, CNT_W'(4)}) begin
            nErrors++;
            $display("[TB] FAIL full_ready ready=%b usage=%0d required 0 4", fpu_ready_o, usage_o);
        end
        driveFpu(64'hDEAD, 5'b11111, 5'd5);
        advance();
        idleInputs();
        nChecks++;
        if ({usage_o, wb_tag_o} !== {CNT_W'(4), 5'd1}) begin
            nErrors++;
            $display("[TB] FAIL full_refuse usage=%0d tag=%0d required 4 1", usage_o, wb_tag_o);
        end
        for (int s = 0; s < 3; s++) begin
            advance();
            nChecks++;
            if ({wb_valid_o, wb_result_o, wb_tag_o} !== {1'b1, mQueue[0].result, 5'd1}) begin
                nErrors++;
                $display("[TB] FAIL stall_stable res=%h tag=%0d required %h 1",
                         wb_result_o, wb_tag_o, mQueue[0].result);
            end
        end
        wb_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            nChecks++;
            if ({wb_valid_o, wb_tag_o} !== {1'b1, TAG_WIDTH'(i)}) begin
                nErrors++;
                $display("[TB] FAIL drain_order valid=%b tag=%0d required 1 %0d", wb_valid_o, wb_tag_o, i);
            end
            advance();
        end
        idleInputs();
        nChecks++;
        if ({busy_o, usage_o} !== {1'b0, CNT_W'(0)}) begin
            nErrors++;
            $display("[TB] FAIL drain_empty busy=%b usage=%0d required 0 0", busy_o, usage_o);
        end
    endtask

    // Occupancy 2 with simultaneous push and pop across pointer wrap
    task automatic test_back_to_back();
        logic [TAG_WIDTH-1:0] nextTag;
        idleInputs();
        driveFpu({$urandom, $urandom}, 5'b0, 5'd10);
        advance();
        driveFpu({$urandom, $urandom}, 5'b0, 5'd11);
        advance();
        nextTag = 5'd12;
        wb_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            driveFpu({$urandom, $urandom}, 5'b0, nextTag);
            nChecks++;
            if ({usage_o, wb_tag_o} !== {CNT_W'(2), TAG_WIDTH'(10 + i)}) begin
                nErrors++;
                $display("[TB] FAIL b2b cycle=%0d usage=%0d tag=%0d required 2 %0d", i, usage_o, wb_tag_o, 10 + i);
            end
            advance();
            nextTag = nextTag + 5'd1;
        end
        idleInputs();
        wb_ready_i = 1'b1;
        advance();
        advance();
        idleInputs();
    endtask

    // Flush with a simultaneous pop: popped status commits, pushed entry is dropped
    task automatic test_flush();
        idleInputs();
        fflags_clr_i = 1'b1;
        advance();
        idleInputs();
        driveFpu(64'h1, 5'b10000, 5'd20);
        advance();
        driveFpu(64'h2, 5'b00100, 5'd21);
        advance();
        driveFpu(64'h3, 5'b01000, 5'd22);
        flush_i    = 1'b1;
        wb_ready_i = 1'b1;
        advance();
        idleInputs();
        nChecks++;
        if ({fflags_o, usage_o, wb_valid_o, fpu_ready_o} !== {5'b10000, CNT_W'(0), 1'b0, 1'b1}) begin
            nErrors++;
            $display("[TB] FAIL flush fflags=%b usage=%0d valid=%b ready=%b required 10000 0 0 1",
                     fflags_o, usage_o, wb_valid_o, fpu_ready_o);
        end
        advance();
        nChecks++;
        if ({fflags_o, usage_o} !== {5'b10000, CNT_W'(0)}) begin
            nErrors++;
            $display("[TB] FAIL flush_after fflags=%b usage=%0d required 10000 0", fflags_o, usage_o);
        end
    endtask

    // CSR write merged with a committing pop, then a clear
    task automatic test_fflags_csr();
        idleInputs();
        fflags_we_i    = 1'b1;
        fflags_wdata_i = 5'b10000;
        advance();
        idleInputs();
        driveFpu(64'h4, 5'b00001, 5'd7);
        advance();
        idleInputs();
        nChecks++;
        if (fflags_o !== 5'b10000) begin
            nErrors++;
            $display("[TB] FAIL csr_write fflags=%b required 10000", fflags_o);
        end
        fflags_we_i    = 1'b1;
        fflags_wdata_i = 5'b00100;
        wb_ready_i     = 1'b1;
        advance();
        idleInputs();
        nChecks++;
        if (fflags_o !== 5'b00101) begin
            nErrors++;
            $display("[TB] FAIL csr_write_pop fflags=%b required 00101", fflags_o);
        end
        fflags_clr_i = 1'b1;
        advance();
        idleInputs();
        nChecks++;
        if (fflags_o !== 5'b00000) begin
            nErrors++;
            $display("[TB] FAIL csr_clear fflags=%b required 00000", fflags_o);
        end
    endtask

    // Random traffic compared cycle by cycle against the queue model
    task automatic test_random();
        idleInputs();
        for (int i = 0; i < 400; i++) begin
            fpu_valid_i    = ($urandom_range(0, 3) != 0);
            fpu_result_i   = {$urandom, $urandom};
            fpu_status_i   = 5'($urandom);
            fpu_tag_i      = TAG_WIDTH'($urandom);
            wb_ready_i     = ($urandom_range(0, 2) != 0);
            flush_i        = ($urandom_range(0, 29) == 0);
            fflags_we_i    = ($urandom_range(0, 19) == 0);
            fflags_clr_i   = ($urandom_range(0, 19) == 0);
            fflags_wdata_i = 5'($urandom);
            nChecks++;
            if ({fpu_ready_o, wb_valid_o, busy_o, usage_o, fflags_o} !==
                {(mQueue.size() != DEPTH), (mQueue.size() != 0), (mQueue.size() != 0),
                 CNT_W'(mQueue.size()), mFflags}) begin
                nErrors++;
                $display("[TB] FAIL rand_ctrl cycle=%0d ready=%b valid=%b busy=%b usage=%0d fflags=%b required size=%0d fflags=%b",
                         i, fpu_ready_o, wb_valid_o, busy_o, usage_o, fflags_o, mQueue.size(), mFflags);
            end
            if (mQueue.size() != 0) begin
                nChecks++;
                if ({wb_result_o, wb_status_o, wb_tag_o} !== {mQueue[0].result, mQueue[0].status, mQueue[0].tag}) begin
                    nErrors++;
                    $display("[TB] FAIL rand_head cycle=%0d res=%h st=%b tag=%0d required %h %b %0d",
                             i, wb_result_o, wb_status_o, wb_tag_o, mQueue[0].result, mQueue[0].status, mQueue[0].tag);
                end
            end
            advance();
        end
        idleInputs();
        wb_ready_i = 1'b1;
        repeat (DEPTH) advance();
        idleInputs();
    endtask

    // Asynchronous reset while entries and flags are held
    task automatic test_reset_midstream();
        idleInputs();
        fflags_we_i    = 1'b1;
        fflags_wdata_i = 5'b11010;
        advance();
        idleInputs();
        for (int i = 0; i < 3; i++) begin
            driveFpu({$urandom, $urandom}, 5'b00010, TAG_WIDTH'(i));
            advance();
        end
        idleInputs();
        nChecks++;
        if ({usage_o, fflags_o} !== {CNT_W'(3), 5'b11010}) begin
            nErrors++;
            $display("[TB] FAIL pre_reset usage=%0d fflags=%b required 3 11010", usage_o, fflags_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        mQueue.delete();
        mFflags = '0;
        nChecks++;
        if ({wb_valid_o, usage_o, fflags_o, fpu_ready_o, busy_o} !== {1'b0, CNT_W'(0), 5'b0, 1'b1, 1'b0}) begin
            nErrors++;
            $display("[TB] FAIL async_reset valid=%b usage=%0d fflags=%b ready=%b busy=%b required 0 0 00000 1 0",
                     wb_valid_o, usage_o, fflags_o, fpu_ready_o, busy_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        advance();
        nChecks++;
        if ({wb_valid_o, usage_o, fflags_o, fpu_ready_o} !== {1'b0, CNT_W'(0), 5'b0, 1'b1}) begin
            nErrors++;
            $display("[TB] FAIL reset_release valid=%b usage=%0d fflags=%b ready=%b required 0 0 00000 1",
                     wb_valid_o, usage_o, fflags_o, fpu_ready_o);
        end
    endtask

    // Run every scenario in sequence, then report
    initial begin
        rst_ni = 1'b0;
        idleInputs();
        @(negedge clk_i);
        test_reset();
        test_single();
        test_full_stall();
        test_back_to_back();
        test_flush();
        test_fflags_csr();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
